// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       branch;
  logic       ext_zero;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           branch, ext_zero, trap, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           branch, ext_zero, trap, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath selects and enables, and traps on illegal opcodes or
// memory accesses that stall longer than WAIT_LIMIT cycles (0 = no watchdog).
module mips_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input logic             clk,
  input logic             reset_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       in_mem_state;
  logic       wd_expire;
  logic       logic_imm;

  // Decoded (ungated) outputs
  logic       dec_pc_write;
  logic       dec_ir_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_i_or_d;
  logic       dec_reg_write;
  logic       dec_reg_dst;
  logic       dec_mem_to_reg;
  logic       dec_alu_src_a;
  logic [1:0] dec_alu_src_b;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_pc_src;
  logic       dec_branch;
  logic       dec_ext_zero;
  logic       dec_trap;

  // State and watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Watchdog: counts consecutive not-ready cycles in a memory state; any other
  // cycle clears it, which also covers clearing on entry to a memory state.
  // Expiry fires on the cycle whose increment would reach WAIT_LIMIT, so a
  // completing access (mem_ready=1) in that cycle still wins.
  always_comb begin
    in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);
    wd_expire    = 1'b0;
    wait_d       = '0;
    if (in_mem_state && !bus.mem_ready) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      if ((WAIT_LIMIT != 0) && ((32'(wait_q) + 32'd1) == WAIT_LIMIT)) begin
        wd_expire = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_R:                       state_d = S_EXECUTE;
          OP_BEQ:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IMMEXEC;
          OP_J:                       state_d = S_JUMP;
          default:                    state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_TRAP;
      end
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_IMMEXEC: state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
    if (wd_expire) state_d = S_TRAP;
  end

  // Moore output decode (opcode only selects the immediate flavour)
  always_comb begin
    dec_pc_write   = 1'b0;
    dec_ir_write   = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_i_or_d     = 1'b0;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src_a  = 1'b0;
    dec_alu_src_b  = 2'b00;
    dec_alu_op     = 2'b00;
    dec_pc_src     = 2'b00;
    dec_branch     = 1'b0;
    dec_ext_zero   = 1'b0;
    dec_trap       = 1'b0;
    logic_imm      = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
    unique case (state_q)
      S_FETCH: begin
        dec_mem_read  = 1'b1;
        dec_alu_src_b = 2'b01;
        dec_ir_write  = bus.mem_ready;
        dec_pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        dec_alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        dec_mem_read = 1'b1;
        dec_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        dec_mem_write = 1'b1;
        dec_i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        dec_alu_src_a = 1'b1;
        dec_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        dec_alu_src_a = 1'b1;
        dec_alu_op    = 2'b01;
        dec_pc_src    = 2'b01;
        dec_branch    = 1'b1;
      end
      S_IMMEXEC: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b10;
        dec_alu_op    = logic_imm ? 2'b11 : 2'b00;
        dec_ext_zero  = logic_imm;
      end
      S_IMMWB: begin
        dec_reg_write = 1'b1;
        dec_ext_zero  = logic_imm;
      end
      S_JUMP: begin
        dec_pc_write = 1'b1;
        dec_pc_src   = 2'b10;
      end
      S_TRAP: begin
        dec_trap = 1'b1;
      end
      default: begin
        dec_trap = 1'b1;
      end
    endcase
  end

  // Hold every output low while reset is asserted, independent of the clock
  always_comb begin
    bus.pc_write   = reset_n & dec_pc_write;
    bus.ir_write   = reset_n & dec_ir_write;
    bus.mem_read   = reset_n & dec_mem_read;
    bus.mem_write  = reset_n & dec_mem_write;
    bus.i_or_d     = reset_n & dec_i_or_d;
    bus.reg_write  = reset_n & dec_reg_write;
    bus.reg_dst    = reset_n & dec_reg_dst;
    bus.mem_to_reg = reset_n & dec_mem_to_reg;
    bus.alu_src_a  = reset_n & dec_alu_src_a;
    bus.alu_src_b  = reset_n ? dec_alu_src_b : '0;
    bus.alu_op     = reset_n ? dec_alu_op : '0;
    bus.pc_src     = reset_n ? dec_pc_src : '0;
    bus.branch     = reset_n & dec_branch;
    bus.ext_zero   = reset_n & dec_ext_zero;
    bus.trap       = reset_n & dec_trap;
    bus.state      = reset_n ? state_q : '0;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus process pushes the
// hand-derived output vector for each cycle; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       trap;
    logic       ext_zero;
    logic       branch;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
  } outs_t;

  localparam outs_t E_ZERO      = '{default: '0};
  localparam outs_t E_FETCH_W   = '{st: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam outs_t E_FETCH_R   = '{st: 4'd0, mem_read: 1'b1, alu_src_b: 2'b01,
                                    ir_write: 1'b1, pc_write: 1'b1, default: '0};
  localparam outs_t E_DECODE    = '{st: 4'd1, alu_src_b: 2'b11, default: '0};
  localparam outs_t E_MEMADR    = '{st: 4'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam outs_t E_MEMRD     = '{st: 4'd3, mem_read: 1'b1, i_or_d: 1'b1, default: '0};
  localparam outs_t E_MEMWB     = '{st: 4'd4, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
  localparam outs_t E_MEMWR     = '{st: 4'd5, mem_write: 1'b1, i_or_d: 1'b1, default: '0};
  localparam outs_t E_EXEC      = '{st: 4'd6, alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam outs_t E_ALUWB     = '{st: 4'd7, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
  localparam outs_t E_BRANCH    = '{st: 4'd8, alu_src_a: 1'b1, alu_op: 2'b01, pc_src: 2'b01,
                                    branch: 1'b1, default: '0};
  localparam outs_t E_IMMX_ADD  = '{st: 4'd9, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam outs_t E_IMMX_LOG  = '{st: 4'd9, alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 2'b11,
                                    ext_zero: 1'b1, default: '0};
  localparam outs_t E_IMMWB_ADD = '{st: 4'd10, reg_write: 1'b1, default: '0};
  localparam outs_t E_IMMWB_LOG = '{st: 4'd10, reg_write: 1'b1, ext_zero: 1'b1, default: '0};
  localparam outs_t E_JUMP      = '{st: 4'd11, pc_write: 1'b1, pc_src: 2'b10, default: '0};
  localparam outs_t E_TRAP      = '{st: 4'd15, trap: 1'b1, default: '0};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus_if();

  mips_multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  outs_t exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  outs_t got_w;
  assign got_w = '{st: bus_if.state, trap: bus_if.trap, ext_zero: bus_if.ext_zero,
                   branch: bus_if.branch, pc_src: bus_if.pc_src, alu_op: bus_if.alu_op,
                   alu_src_b: bus_if.alu_src_b, alu_src_a: bus_if.alu_src_a,
                   mem_to_reg: bus_if.mem_to_reg, reg_dst: bus_if.reg_dst,
                   reg_write: bus_if.reg_write, i_or_d: bus_if.i_or_d,
                   mem_write: bus_if.mem_write, mem_read: bus_if.mem_read,
                   ir_write: bus_if.ir_write, pc_write: bus_if.pc_write};

  // Monitor: one expected vector per driven cycle, checked mid-cycle
  outs_t mon_e;
  string mon_t;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      total++;
      if (got_w !== mon_e) begin
        bad++;
        $display("FAIL %s: got=%h (state=%0d) expected=%h (state=%0d)",
                 mon_t, got_w, got_w.st, mon_e, mon_e.st);
      end
    end
  end

  task automatic cyc(input logic [5:0] op, input logic mr, input logic rn,
                     input outs_t e, input string t);
    @(posedge clk);
    #1;
    reset_n           = rn;
    bus_if.opcode    = op;
    bus_if.mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus_if.opcode    = 6'h00;
    bus_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    cyc(6'h00, 1'b1, 1'b0, E_ZERO,      "reset_hold");
    // lw, zero wait states: 0,1,2,3,4,0
    cyc(6'h23, 1'b1, 1'b1, E_FETCH_R,   "lw_fetch_after_release");
    cyc(6'h23, 1'b1, 1'b1, E_DECODE,    "lw_decode");
    cyc(6'h23, 1'b1, 1'b1, E_MEMADR,    "lw_memadr");
    cyc(6'h23, 1'b1, 1'b1, E_MEMRD,     "lw_memrd");
    cyc(6'h23, 1'b1, 1'b1, E_MEMWB,     "lw_memwb");
    // sw with three stall cycles; the ready on the 4th cycle lands at the
    // watchdog limit and must complete normally
    cyc(6'h2B, 1'b1, 1'b1, E_FETCH_R,   "sw_fetch");
    cyc(6'h2B, 1'b1, 1'b1, E_DECODE,    "sw_decode");
    cyc(6'h2B, 1'b0, 1'b1, E_MEMADR,    "sw_memadr_ready_ignored");
    cyc(6'h2B, 1'b0, 1'b1, E_MEMWR,     "sw_memwr_stall1");
    cyc(6'h2B, 1'b0, 1'b1, E_MEMWR,     "sw_memwr_stall2");
    cyc(6'h2B, 1'b0, 1'b1, E_MEMWR,     "sw_memwr_stall3");
    cyc(6'h2B, 1'b1, 1'b1, E_MEMWR,     "sw_memwr_done_at_limit");
    // ori (zero-extend, logic op)
    cyc(6'h0D, 1'b1, 1'b1, E_FETCH_R,   "ori_fetch");
    cyc(6'h0D, 1'b1, 1'b1, E_DECODE,    "ori_decode");
    cyc(6'h0D, 1'b1, 1'b1, E_IMMX_LOG,  "ori_immexec");
    cyc(6'h0D, 1'b1, 1'b1, E_IMMWB_LOG, "ori_immwb");
    // addi (sign-extend, add), with one fetch stall
    cyc(6'h08, 1'b0, 1'b1, E_FETCH_W,   "addi_fetch_stall");
    cyc(6'h08, 1'b1, 1'b1, E_FETCH_R,   "addi_fetch");
    cyc(6'h08, 1'b1, 1'b1, E_DECODE,    "addi_decode");
    cyc(6'h08, 1'b1, 1'b1, E_IMMX_ADD,  "addi_immexec");
    cyc(6'h08, 1'b1, 1'b1, E_IMMWB_ADD, "addi_immwb");
    // andi
    cyc(6'h0C, 1'b1, 1'b1, E_FETCH_R,   "andi_fetch");
    cyc(6'h0C, 1'b1, 1'b1, E_DECODE,    "andi_decode");
    cyc(6'h0C, 1'b1, 1'b1, E_IMMX_LOG,  "andi_immexec");
    cyc(6'h0C, 1'b1, 1'b1, E_IMMWB_LOG, "andi_immwb");
    // R-type, mem_ready low outside memory states
    cyc(6'h00, 1'b1, 1'b1, E_FETCH_R,   "r_fetch");
    cyc(6'h00, 1'b0, 1'b1, E_DECODE,    "r_decode");
    cyc(6'h00, 1'b0, 1'b1, E_EXEC,      "r_execute");
    cyc(6'h00, 1'b0, 1'b1, E_ALUWB,     "r_aluwb");
    // beq then j, 3 cycles each
    cyc(6'h04, 1'b1, 1'b1, E_FETCH_R,   "beq_fetch");
    cyc(6'h04, 1'b1, 1'b1, E_DECODE,    "beq_decode");
    cyc(6'h04, 1'b1, 1'b1, E_BRANCH,    "beq_branch");
    cyc(6'h02, 1'b1, 1'b1, E_FETCH_R,   "j_fetch");
    cyc(6'h02, 1'b1, 1'b1, E_DECODE,    "j_decode");
    cyc(6'h02, 1'b1, 1'b1, E_JUMP,      "j_jump");
    // lw with one read stall
    cyc(6'h23, 1'b1, 1'b1, E_FETCH_R,   "lw2_fetch");
    cyc(6'h23, 1'b1, 1'b1, E_DECODE,    "lw2_decode");
    cyc(6'h23, 1'b1, 1'b1, E_MEMADR,    "lw2_memadr");
    cyc(6'h23, 1'b0, 1'b1, E_MEMRD,     "lw2_memrd_stall");
    cyc(6'h23, 1'b1, 1'b1, E_MEMRD,     "lw2_memrd_done");
    cyc(6'h23, 1'b1, 1'b1, E_MEMWB,     "lw2_memwb");
    // reset asserted mid-MEMWR: outputs drop at once, write discarded
    cyc(6'h2B, 1'b1, 1'b1, E_FETCH_R,   "sw2_fetch");
    cyc(6'h2B, 1'b1, 1'b1, E_DECODE,    "sw2_decode");
    cyc(6'h2B, 1'b1, 1'b1, E_MEMADR,    "sw2_memadr");
    cyc(6'h2B, 1'b0, 1'b1, E_MEMWR,     "sw2_memwr");
    cyc(6'h2B, 1'b1, 1'b0, E_ZERO,      "reset_mid_memwr");
    cyc(6'h08, 1'b1, 1'b1, E_FETCH_R,   "release_fetch");
    cyc(6'h08, 1'b1, 1'b1, E_DECODE,    "release_decode");
    cyc(6'h08, 1'b1, 1'b1, E_IMMX_ADD,  "release_immexec");
    cyc(6'h08, 1'b1, 1'b1, E_IMMWB_ADD, "release_immwb");
    // illegal opcode -> sticky trap
    cyc(6'h3F, 1'b1, 1'b1, E_FETCH_R,   "illegal_fetch");
    cyc(6'h3F, 1'b1, 1'b1, E_DECODE,    "illegal_decode");
    cyc(6'h3F, 1'b1, 1'b1, E_TRAP,      "illegal_trap");
    cyc(6'h23, 1'b1, 1'b1, E_TRAP,      "illegal_trap_sticky1");
    cyc(6'h00, 1'b0, 1'b1, E_TRAP,      "illegal_trap_sticky2");
    // watchdog: mem_ready held low in FETCH, WAIT_LIMIT=4 -> trap in cycle 5
    cyc(6'h00, 1'b0, 1'b0, E_ZERO,      "reset_before_wd");
    cyc(6'h00, 1'b0, 1'b1, E_FETCH_W,   "wd_cycle1");
    cyc(6'h00, 1'b0, 1'b1, E_FETCH_W,   "wd_cycle2");
    cyc(6'h00, 1'b0, 1'b1, E_FETCH_W,   "wd_cycle3");
    cyc(6'h00, 1'b0, 1'b1, E_FETCH_W,   "wd_cycle4");
    cyc(6'h00, 1'b0, 1'b1, E_TRAP,      "wd_cycle5_trap");
    cyc(6'h00, 1'b1, 1'b1, E_TRAP,      "wd_trap_sticky");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives every datapath mux and write-enable, including the immediate extender mode (sign vs zero extend). It sits between the instruction register opcode field and the datapath. It handles a ready handshake to instruction/data memory and watches for memory stalls.

Parameters:
WAIT_LIMIT, 16, max consecutive cycles with mem_ready=0 in one memory state before trap; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], stable from DECODE until the next FETCH completes
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC load enable
ir_write  output  1  IR load enable
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
reg_write  output  1  register file write enable
reg_dst  output  1  write register select: 0=rt, 1=rd
mem_to_reg  output  1  writeback data select: 0=ALUOut, 1=MDR
alu_src_a  output  1  ALU A select: 0=PC, 1=reg A
alu_src_b  output  2  ALU B select: 00=reg B, 01=const 4, 10=extended imm, 11=extended imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decoded, 11=logic-imm (opcode-decoded)
pc_src  output  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump target
branch  output  1  PC load enable qualified by zero flag (beq)
ext_zero  output  1  extender mode: 0=sign-extend, 1=zero-extend
trap  output  1  sticky error: illegal opcode or memory watchdog expiry
state  output  4  current state encoding, for debug

Behaviour:
- Registered 4-bit state. reset_n low asynchronously forces state=FETCH (0), clears the wait counter, and forces all outputs to 0 combinationally while it is low.
- Outputs are Moore-decoded from state (and opcode where noted). Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11, TRAP=15.
- Opcodes: R=6'h00, j=6'h02, beq=6'h04, addi=6'h08, andi=6'h0C, ori=6'h0D, lw=6'h23, sw=6'h2B.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready. mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_zero=0 (branch target precompute). Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq -> BRANCH
  - addi/andi/ori -> IMMEXEC
  - j -> JUMP
  - any other opcode -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_zero=0. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. mem_ready -> MEMWB; otherwise stay.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1, held until mem_ready. mem_ready -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10. addi: alu_op=00, ext_zero=0. andi/ori: alu_op=11, ext_zero=1. -> IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, with the same ext_zero as IMMEXEC -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- TRAP: trap=1; all other outputs 0. State holds until reset_n is asserted.
- Cycle counts with zero wait states:
  - lw = 5 cycles; sw, R, addi/andi/ori = 4; beq, j = 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Watchdog: 8-bit counter, cleared on entry to any memory state and on mem_ready=1, incremented on each mem_ready=0 cycle while in FETCH, MEMRD or MEMWR.
  - WAIT_LIMIT>0 and count reaches WAIT_LIMIT with mem_ready still 0 -> TRAP on the next edge.
  - mem_ready=1 in the same cycle as the limit takes priority: the access completes normally.
- mem_ready is ignored in non-memory states.
- Reset mid-instruction discards any pending write. No reg_write or mem_write is asserted while reset_n is low or in the cycle after release; the FSM restarts at FETCH.

Test Plan:
- Reset low mid-MEMWR with mem_write=1 -> all outputs 0 immediately, state=0. Release with mem_ready=1 -> ir_write=1, pc_write=1, mem_read=1 in cycle 1; state=1 next.
- lw (opcode 6'h23), mem_ready always 1 -> states 0,1,2,3,4,0. MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- sw (6'h2B) with mem_ready low 3 cycles in MEMWR -> mem_write=1, i_or_d=1 held 4 cycles; state returns to 0; reg_write never 1.
- ori (6'h0D) vs addi (6'h08) -> IMMEXEC ext_zero=1, alu_op=11 for ori; ext_zero=0, alu_op=00 for addi. Both reach IMMWB with reg_write=1, reg_dst=0.
- beq (6'h04) then j (6'h02) -> BRANCH: branch=1, pc_src=01, alu_op=01. JUMP: pc_write=1, pc_src=10. Each takes 3 cycles.
- Opcode 6'h3F -> TRAP after DECODE, trap=1 sticky. Separately, WAIT_LIMIT=4 with mem_ready held 0 in FETCH -> trap=1 at cycle 5, state=15.
